scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised N-channel, W-bit registered selector; successor to the 2-input combinational mux.
- Holds its channel select in an internal register. The select is either loaded explicitly (manual mode) or stepped by a wrap-around counter (scan mode).
- Output is registered, one cycle of latency.
- Used for register-file read ports, I/O port polling and bus sharing where a select must persist across cycles.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_BITS, 2, select width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  CHANNELS*WIDTH  packed inputs; channel k occupies d[k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SEL_BITS  select value to load.
- sel_load  input  1  load sel_in into the select register (either mode).
- advance  input  1  step the select register (scan mode only).
- hold  input  1  freeze q and q_valid; sel still updates.
- q  output  WIDTH  registered selected data.
- q_valid  output  1  q holds a sample taken since reset.
- sel  output  SEL_BITS  current select register value.
- wrap  output  1  one-cycle pulse when scan steps from CHANNELS-1 to 0.
- sel_err  output  1  one-cycle pulse on rejected out-of-range load.

Behaviour:
- Reset (rst=1 at an edge): sel=0, q=0, q_valid=0, wrap=0, sel_err=0. Reset overrides every other input, including mid-scan; it takes effect at that edge.
- Output path, each edge with rst=0 and hold=0:
  - q <= d[channel given by pre-edge sel]; q_valid <= 1.
  - q therefore reflects d one cycle after sel settles. Changing sel at edge n gives new-channel data on q after edge n+1.
- hold=1: q and q_valid keep their values; the select logic still operates.
- Select update priority, highest first, evaluated every edge with rst=0:
  1. sel_load=1 and sel_in < CHANNELS: sel <= sel_in; wrap <= 0.
  2. sel_load=1 and sel_in >= CHANNELS: sel unchanged; sel_err <= 1 for one cycle. Only possible when CHANNELS is not a power of two.
  3. mode=1 and advance=1: if sel == CHANNELS-1, then sel <= 0 and wrap <= 1; otherwise sel <= sel+1 and wrap <= 0.
  4. Otherwise sel unchanged, wrap <= 0, sel_err <= 0.
- A load always wins over a simultaneous advance; the advance is dropped, not deferred.
- mode=0: advance is ignored entirely, and wrap never pulses.
- Switching mode does not alter sel; scanning resumes from the current value.
- wrap and sel_err are registered pulses, high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- sel never holds a value >= CHANNELS under any input sequence.
- Width rule: the select increment is SEL_BITS wide, with explicit compare-and-clear at CHANNELS-1. Natural overflow is not relied on.

Test Plan:
- Reset then run: d = {ch3=0xD3, ch2=0xC2, ch1=0xB1, ch0=0xA0}; rst high 2 cycles then low -> q=0x00, q_valid=0 while in reset; q=0xA0, q_valid=1 after the first free edge.
- Manual load with latency: mode=0, pulse sel_load with sel_in=2 at edge n -> sel=2 after edge n; q=0xC2 after edge n+1; advance=1 has no effect in mode 0.
- Scan wrap: mode=1, advance held high 5 cycles from sel=0 -> sel sequence 1,2,3,0,1; wrap high for exactly the cycle sel becomes 0; q trails sel by one cycle.
- Load vs advance collision: mode=1, sel=1, sel_load=1 with sel_in=3 and advance=1 on the same edge -> sel=3, wrap=0; next advance -> sel=0, wrap=1.
- Out of range and hold: CHANNELS=3, SEL_BITS=2, sel=1, sel_in=3 loaded -> sel stays 1, sel_err pulses one cycle. Then hold=1 with d changed -> q frozen while sel still scans.
- Reset mid-scan: mode=1, advance=1, sel=2, rst asserted one edge -> sel=0, q=0, q_valid=0, wrap=0 regardless of advance.

Source files
------------

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : scan_mux
// Brief   : N-channel registered selector. The channel select is either loaded
//           directly or stepped by a wrap-around scan counter.
// Revision: 1.0  initial release
// ============================================================================
module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_BITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   d,
    input  logic                        mode,
    input  logic [SEL_BITS-1:0]         sel_in,
    input  logic                        sel_load,
    input  logic                        advance,
    input  logic                        hold,
    output logic [WIDTH-1:0]            q,
    output logic                        q_valid,
    output logic [SEL_BITS-1:0]         sel,
    output logic                        wrap,
    output logic                        sel_err
);

    // One extra bit so CHANNELS itself is representable when it is a power of two.
    localparam logic [SEL_BITS:0]   c_num_chan = (SEL_BITS+1)'(CHANNELS);
    localparam logic [SEL_BITS-1:0] c_last_sel = SEL_BITS'(CHANNELS - 1);

    logic [WIDTH-1:0]    w_chan [CHANNELS];
    logic [WIDTH-1:0]    w_data;
    logic [SEL_BITS-1:0] w_sel_nxt;
    logic                w_wrap_nxt;
    logic                w_err_nxt;

    logic [WIDTH-1:0]    r_q;
    logic                r_q_valid;
    logic [SEL_BITS-1:0] r_sel;
    logic                r_wrap;
    logic                r_sel_err;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            assign w_chan[k] = d[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Compare-based select keeps unused select codes from indexing past the array.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_sel == SEL_BITS'(k)) begin
                w_data = w_chan[k];
            end
        end
    end

    always_comb begin
        w_sel_nxt  = r_sel;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (sel_load) begin
            if ({1'b0, sel_in} < c_num_chan) begin
                w_sel_nxt = sel_in;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (mode && advance) begin
            if (r_sel == c_last_sel) begin
                w_sel_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_sel_nxt = r_sel + SEL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_sel     <= '0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            if (!hold) begin
                r_q       <= w_data;
                r_q_valid <= 1'b1;
            end
            r_sel     <= w_sel_nxt;
            r_wrap    <= w_wrap_nxt;
            r_sel_err <= w_err_nxt;
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign sel     = r_sel;
    assign wrap    = r_wrap;
    assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_scan_mux
// Brief   : Self-checking bench for scan_mux; 4-channel and 3-channel instances
//           share stimulus and are checked against a reference scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_scan_mux;

    typedef struct packed {
        logic [7:0] q;
        logic       qv;
        logic [1:0] sel;
        logic       wrap;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d = 32'hD3C2B1A0;
    logic        mode = 1'b0;
    logic [1:0]  sel_in = 2'd0;
    logic        sel_load = 1'b0;
    logic        advance = 1'b0;
    logic        hold = 1'b0;

    logic [7:0]  q4, q3;
    logic        qv4, qv3;
    logic [1:0]  sel4, sel3;
    logic        wrap4, wrap3;
    logic        err4, err3;

    int checks = 0;
    int failures = 0;

    exp_t m4 = '0;
    exp_t m3 = '0;
    exp_t sb4 [$];
    exp_t sb3 [$];

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_BITS(2)) dut4 (
        .clk(clk), .rst(rst), .d(d), .mode(mode), .sel_in(sel_in),
        .sel_load(sel_load), .advance(advance), .hold(hold),
        .q(q4), .q_valid(qv4), .sel(sel4), .wrap(wrap4), .sel_err(err4)
    );

    scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .d(d[23:0]), .mode(mode), .sel_in(sel_in),
        .sel_load(sel_load), .advance(advance), .hold(hold),
        .q(q3), .q_valid(qv3), .sel(sel3), .wrap(wrap3), .sel_err(err3)
    );

    // Reference model: state after the coming edge, given the current inputs.
    function automatic exp_t model_next(exp_t s, int n, logic [31:0] dd);
        exp_t r;
        int   cur;
        r   = s;
        cur = int'(s.sel);
        if (rst) return '0;
        if (!hold) begin
            r.q  = dd[cur*8 +: 8];
            r.qv = 1'b1;
        end
        r.wrap = 1'b0;
        r.err  = 1'b0;
        if (sel_load) begin
            if (int'(sel_in) < n) r.sel = sel_in;
            else                  r.err = 1'b1;
        end else if (mode && advance) begin
            r.sel  = 2'((cur + 1) % n);
            r.wrap = (cur == n - 1);
        end
        return r;
    endfunction

    task automatic tick();
        m4 = model_next(m4, 4, d);
        m3 = model_next(m3, 3, {8'h00, d[23:0]});
        sb4.push_back(m4);
        sb3.push_back(m3);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pops the expectation for each edge once the DUT outputs settle.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            checks++;
            if ({q4, qv4, sel4, wrap4, err4} !== e) begin
                failures++;
                $display("FAIL sb4 t=%0t actual q=%h qv=%b sel=%0d wrap=%b err=%b required q=%h qv=%b sel=%0d wrap=%b err=%b",
                         $time, q4, qv4, sel4, wrap4, err4, e.q, e.qv, e.sel, e.wrap, e.err);
            end
        end
        if (sb3.size() > 0) begin
            e = sb3.pop_front();
            checks++;
            if ({q3, qv3, sel3, wrap3, err3} !== e) begin
                failures++;
                $display("FAIL sb3 t=%0t actual q=%h qv=%b sel=%0d wrap=%b err=%b required q=%h qv=%b sel=%0d wrap=%b err=%b",
                         $time, q3, qv3, sel3, wrap3, err3, e.q, e.qv, e.sel, e.wrap, e.err);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        d   = 32'hD3C2B1A0;
        tick();
        tick();
        checks++;
        if ({q4, qv4, sel4} !== {8'h00, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_hold actual q=%h qv=%b sel=%0d required q=00 qv=0 sel=0", q4, qv4, sel4);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({q4, qv4} !== {8'hA0, 1'b1}) begin
            failures++;
            $display("FAIL reset_release actual q=%h qv=%b required q=a0 qv=1", q4, qv4);
        end
    endtask

    task automatic test_manual_load();
        mode     = 1'b0;
        advance  = 1'b1;
        sel_load = 1'b1;
        sel_in   = 2'd2;
        tick();
        sel_load = 1'b0;
        checks++;
        if ({sel4, q4} !== {2'd2, 8'hA0}) begin
            failures++;
            $display("FAIL manual_edge_n actual sel=%0d q=%h required sel=2 q=a0", sel4, q4);
        end
        tick();
        checks++;
        if ({sel4, q4, wrap4} !== {2'd2, 8'hC2, 1'b0}) begin
            failures++;
            $display("FAIL manual_edge_n1 actual sel=%0d q=%h wrap=%b required sel=2 q=c2 wrap=0", sel4, q4, wrap4);
        end
        advance = 1'b0;
    endtask

    task automatic test_scan_wrap();
        logic [1:0] exp_sel  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic       exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_q    [5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
        sel_load = 1'b1;
        sel_in   = 2'd0;
        tick();
        sel_load = 1'b0;
        mode     = 1'b1;
        advance  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({sel4, wrap4, q4} !== {exp_sel[i], exp_wrap[i], exp_q[i]}) begin
                failures++;
                $display("FAIL scan_step%0d actual sel=%0d wrap=%b q=%h required sel=%0d wrap=%b q=%h",
                         i, sel4, wrap4, q4, exp_sel[i], exp_wrap[i], exp_q[i]);
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_collision();
        mode     = 1'b1;
        sel_load = 1'b1;
        sel_in   = 2'd1;
        tick();
        advance = 1'b1;
        sel_in  = 2'd3;
        tick();
        sel_load = 1'b0;
        checks++;
        if ({sel4, wrap4, sel3, err3} !== {2'd3, 1'b0, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL collision actual sel4=%0d wrap4=%b sel3=%0d err3=%b required sel4=3 wrap4=0 sel3=1 err3=1",
                     sel4, wrap4, sel3, err3);
        end
        tick();
        checks++;
        if ({sel4, wrap4, sel3, err3} !== {2'd0, 1'b1, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL collision_next actual sel4=%0d wrap4=%b sel3=%0d err3=%b required sel4=0 wrap4=1 sel3=2 err3=0",
                     sel4, wrap4, sel3, err3);
        end
        advance = 1'b0;
    endtask

    task automatic test_range_hold();
        mode     = 1'b0;
        sel_load = 1'b1;
        sel_in   = 2'd1;
        tick();
        sel_in = 2'd3;
        tick();
        checks++;
        if ({sel3, err3} !== {2'd1, 1'b1}) begin
            failures++;
            $display("FAIL range_reject actual sel=%0d err=%b required sel=1 err=1", sel3, err3);
        end
        tick();
        checks++;
        if ({sel3, err3} !== {2'd1, 1'b1}) begin
            failures++;
            $display("FAIL range_back_to_back actual sel=%0d err=%b required sel=1 err=1", sel3, err3);
        end
        sel_load = 1'b0;
        tick();
        checks++;
        if ({err3, q3, q4} !== {1'b0, 8'hB1, 8'hD3}) begin
            failures++;
            $display("FAIL range_clear actual err=%b q3=%h q4=%h required err=0 q3=b1 q4=d3", err3, q3, q4);
        end
        hold    = 1'b1;
        mode    = 1'b1;
        advance = 1'b1;
        d       = 32'h44332211;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({q3, qv3, sel3, q4} !== {8'hB1, 1'b1, 2'((2 + i) % 3), 8'hD3}) begin
                failures++;
                $display("FAIL hold_step%0d actual q3=%h qv3=%b sel3=%0d q4=%h required q3=b1 qv3=1 sel3=%0d q4=d3",
                         i, q3, qv3, sel3, q4, (2 + i) % 3);
            end
        end
        hold    = 1'b0;
        advance = 1'b0;
        tick();
        checks++;
        if (q3 !== 8'h22) begin
            failures++;
            $display("FAIL hold_release actual q3=%h required q3=22", q3);
        end
    endtask

    task automatic test_reset_mid_scan();
        d        = 32'hD3C2B1A0;
        mode     = 1'b1;
        sel_load = 1'b1;
        sel_in   = 2'd2;
        tick();
        sel_load = 1'b0;
        advance  = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({sel4, q4, qv4, wrap4, sel3, qv3} !== {2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_scan actual sel4=%0d q4=%h qv4=%b wrap4=%b sel3=%0d qv3=%b required all zero",
                     sel4, q4, qv4, wrap4, sel3, qv3);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({sel4, q4, qv4} !== {2'd1, 8'hA0, 1'b1}) begin
            failures++;
            $display("FAIL after_reset_scan actual sel=%0d q=%h qv=%b required sel=1 q=a0 qv=1", sel4, q4, qv4);
        end
        advance = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_manual_load();
        test_scan_wrap();
        test_collision();
        test_range_hold();
        test_reset_mid_scan();
        #2;
        checks++;
        if ((sb4.size() + sb3.size()) != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual pending=%0d required pending=0", sb4.size() + sb3.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
